muldiv_iter: RTL and testbench
==============================

# muldiv_iter

Parametrised iterative multiply/divide unit for the EX stage, the successor to the fixed 32-bit divider. Signed and unsigned multiply and divide run on a shared radix-2 datapath, one bit per cycle. The unit drives a stall request to the pipeline controller, supports annulment on flush, and delivers a HI/LO result pair to the EX result mux.

## Interface
Parameters:
- WIDTH, 32: operand width; results are 2×WIDTH (hi/lo). Legal values are 8 or more, and a power of two.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request a new operation; sampled in IDLE or DONE only.
- op  in  2  operation select, captured with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opa  in  WIDTH  multiplicand or dividend.
- opb  in  WIDTH  multiplier or divisor.
- annul  in  1  abort the operation in flight (pipeline flush).
- stall_req  out  1  hold the pipeline while an operation is pending.
- done  out  1  one-cycle pulse; result_hi/result_lo are valid.
- result_hi  out  WIDTH  MULT: upper product; DIV: remainder.
- result_lo  out  WIDTH  MULT: lower product; DIV: quotient.
- div_zero  out  1  the last completed divide had opb==0; held until the next start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE/DONE with start=1: capture op, record operand signs, and load the magnitudes |opa|/|opb| (raw values for unsigned ops). Clear the counter. Go to CALC.
- DONE with start=0: go to IDLE. Results stay valid until the next accepted start.
- CALC: perform one iteration per cycle.
  - MULT: shift-add into a 2W accumulator.
  - DIV: restoring shift-subtract, producing a remainder and a quotient bit.
  - After WIDTH iterations, go to DONE. Sign correction is applied on this same transition, so the result registers update entering DONE.
- Sign rules:
  - Signed product is negated if sign(opa)≠sign(opb).
  - Signed quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Signed DIV of min/−1: result_lo = 2^(W−1) (e.g. 0x8000_0000), result_hi = 0, div_zero = 0.
- opb==0 on DIV/DIVU: result_lo = all ones, result_hi = opa unchanged, div_zero = 1. This applies to both signed and unsigned divides.
- start while in CALC is ignored.
- annul in CALC: go to IDLE on the next edge. No done pulse; result_hi, result_lo and div_zero keep their previous values. annul in IDLE or DONE has no effect.
- annul and start in the same cycle in IDLE/DONE: annul has priority and start is dropped.
- stall_req is combinational: (state==CALC & ~annul) | (start & ~annul & state!=CALC). It is low in DONE, so the EX stage samples the result on the same cycle that stall drops.

## Timing
- Reset (async assert, sync release): state=IDLE, counter=0, done=0, result_hi=0, result_lo=0, div_zero=0, stall_req=0 (given start=0).
- Start accepted at edge 0. CALC occupies edges 1..WIDTH. done=1 during cycle WIDTH+1.
- Total latency is WIDTH+1 cycles from start to done (33 for WIDTH=32). stall_req is high for WIDTH+1 cycles.
- Back-to-back: start in the DONE cycle is accepted, and done is followed directly by CALC.
- Reset mid-CALC: immediate return to the reset values; no done pulse.

## Configuration
- MULDIV_EARLY_OUT_EN defined: on the first CALC cycle, the unit jumps straight to DONE (latency 2) in these cases:
  - MULT with either magnitude zero.
  - DIV with opb==0.
  - DIV with |opa|<|opb|, giving quotient 0 and remainder opa.
  
  Results and flags are identical to the full-latency path, and stall_req drops accordingly.
- Not defined: every operation takes exactly WIDTH+1 cycles. No comparison logic is instantiated.

## Test plan
- MULT, WIDTH=32, opa=0xFFFF_FFFE (−2), opb=3 → after 33 cycles done=1, hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; stall_req high for cycles 0..32.
- MULTU, opa=0xFFFF_FFFF, opb=0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV, opa=−7 (0xFFFF_FFF9), opb=2 → lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1); DIVU with the same inputs → lo=0x7FFF_FFFC, hi=1.
- DIVU, opa=5, opb=0 → div_zero=1, lo=0xFFFF_FFFF, hi=5. With MULDIV_EARLY_OUT_EN, done arrives at cycle 2.
- DIV started, annul asserted at cycle 10 → IDLE at cycle 11, done never pulses, stall_req=0 from cycle 10, previous results unchanged.
- DIV 0x8000_0000 / 0xFFFF_FFFF, followed by a start in the DONE cycle → lo=0x8000_0000, hi=0, and the second op's done arrives 33 cycles later. Also check resetn pulsed mid-CALC: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiply/divide unit for the EX stage.
// Signed/unsigned multiply (shift-add) and divide (restoring shift-subtract)
// share one 2xWIDTH accumulator and retire one bit per cycle.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start, op, opa, opb    request + operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   annul                  abort the operation in flight (pipeline flush)
//   stall_req              combinational pipeline hold while an op is pending
//   done                   one-cycle pulse, results valid
//   result_hi, result_lo   MULT: product hi/lo; DIV: remainder/quotient
//   div_zero               last completed divide had a zero divisor
//
// Optional feature: define MULDIV_EARLY_OUT_EN to finish trivial operations
// (zero multiply operand, zero divisor, |dividend| < |divisor|) after one
// CALC cycle.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned W2    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_q, neg_r, dz;
  logic [WIDTH-1:0]   ma, mb, acc_hi, acc_lo;

  logic               accept_c, finish_c, last_c, early_c, sgn_c;
  logic [WIDTH-1:0]   abs_a_c, abs_b_c;
  logic [WIDTH:0]     mul_sum_c, div_sh_c;
  logic               div_ge_c;
  logic [WIDTH-1:0]   div_diff_c;
  logic [WIDTH-1:0]   it_hi_c, it_lo_c, fin_hi_c, fin_lo_c, res_hi_c, res_lo_c;
  logic [W2-1:0]      prod_c;

  assign last_c = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  // Trivial cases are detected on the first CALC cycle only.
  assign early_c = (state == S_CALC) && (cnt == '0) &&
                   (is_div ? ((mb == '0) || (ma < mb)) : ((ma == '0) || (mb == '0)));
`else
  assign early_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next state, stall request and accept/finish strobes
  always_comb begin
    state_nx  = state;
    stall_req = 1'b0;
    accept_c  = 1'b0;
    finish_c  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        // annul beats start; DONE without a new request falls back to IDLE
        if (start && !annul) begin
          state_nx  = S_CALC;
          accept_c  = 1'b1;
          stall_req = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_CALC: begin
        if (annul) begin
          state_nx = S_IDLE;
        end else begin
          stall_req = 1'b1;
          if (last_c || early_c) begin
            state_nx = S_DONE;
            finish_c = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand magnitudes at capture time
  always_comb begin
    sgn_c   = ~op[0];
    abs_a_c = (sgn_c && opa[WIDTH-1]) ? -opa : opa;
    abs_b_c = (sgn_c && opb[WIDTH-1]) ? -opb : opb;
  end

  // One iteration of the shared datapath plus final sign correction
  always_comb begin
    mul_sum_c  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, ma} : '0);
    div_sh_c   = {acc_hi, acc_lo[WIDTH-1]};
    div_ge_c   = (div_sh_c >= {1'b0, mb});
    // only used when div_ge_c, so the wrapped upper bit is irrelevant
    div_diff_c = div_sh_c[WIDTH-1:0] - mb;

    if (is_div) begin
      it_hi_c = div_ge_c ? div_diff_c : div_sh_c[WIDTH-1:0];
      it_lo_c = {acc_lo[WIDTH-2:0], div_ge_c};
    end else begin
      it_hi_c = mul_sum_c[WIDTH:1];
      it_lo_c = {mul_sum_c[0], acc_lo[WIDTH-1:1]};
    end

    // Early out: product 0, or quotient 0 with remainder = |dividend|
    if (early_c) begin
      fin_hi_c = is_div ? ma : '0;
      fin_lo_c = '0;
    end else begin
      fin_hi_c = it_hi_c;
      fin_lo_c = it_lo_c;
    end

    prod_c = {fin_hi_c, fin_lo_c};
    if (neg_q) prod_c = -prod_c;

    if (is_div) begin
      // zero divisor: remainder sign rule already reproduces opa
      res_lo_c = dz ? '1 : (neg_q ? -fin_lo_c : fin_lo_c);
      res_hi_c = neg_r ? -fin_hi_c : fin_hi_c;
    end else begin
      res_hi_c = prod_c[W2-1:WIDTH];
      res_lo_c = prod_c[WIDTH-1:0];
    end
  end

  // Operand capture and accumulator
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (accept_c) begin
      cnt    <= '0;
      is_div <= op[1];
      neg_q  <= sgn_c & (opa[WIDTH-1] ^ opb[WIDTH-1]);
      neg_r  <= sgn_c & op[1] & opa[WIDTH-1];
      dz     <= op[1] & (opb == '0);
      ma     <= abs_a_c;
      mb     <= abs_b_c;
      acc_hi <= '0;
      // divide shifts the dividend out of acc_lo; multiply shifts the multiplier
      acc_lo <= op[1] ? abs_a_c : abs_b_c;
    end else if (state == S_CALC) begin
      cnt    <= cnt + CNT_W'(1);
      acc_hi <= it_hi_c;
      acc_lo <= it_lo_c;
    end
  end

  // Result registers update only on completion; annul leaves them untouched
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done      <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= finish_c;
      if (finish_c) begin
        result_hi <= res_hi_c;
        result_lo <= res_lo_c;
        div_zero  <= dz;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Testbench for muldiv_iter (WIDTH=32): directed vectors with literal
// expectations plus an arithmetic reference model compared every cycle.
module tb_muldiv_iter;

  localparam int unsigned W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         annul = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         stall_req, done, div_zero;
  logic [W-1:0] result_hi, result_lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .annul     (annul),
    .stall_req (stall_req),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .div_zero  (div_zero)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference arithmetic: returns {div_zero, hi, lo}
  function automatic logic [2*W:0] ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sb; return {1'b0, 64'(p)}; end
      2'b01: begin u = 64'(a) * 64'(b); return {1'b0, u}; end
      default: begin
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        if (o == 2'b10) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
          return {1'b0, 32'(sa % sb), 32'(sa / sb)};
        end
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [W-1:0] xa, xb;
    xa = (!o[0] && a[W-1]) ? -a : a;
    xb = (!o[0] && b[W-1]) ? -b : b;
    if (!o[1] && (xa == '0 || xb == '0)) return 2;
    if (o[1] && (b == '0 || xa < xb)) return 2;
`endif
    return W + 1;
  endfunction

  // Cycle-level model: remaining busy cycles and held results
  int           m_busy;
  logic         m_done, m_dz, p_dz;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy = 0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy > 0) begin
        if (annul) m_busy = 0;
        else begin
          m_busy--;
          if (m_busy == 0) begin
            m_done = 1'b1; m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
          end
        end
      end else if (start && !annul) begin
        {p_dz, p_hi, p_lo} = ref_op(op, opa, opb);
        m_busy = lat_of(op, opa, opb) - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      check("m_stall", stall_req, (m_busy > 0 || start) && !annul);
      check("m_done", done, m_done);
      check("m_hi", result_hi, m_hi);
      check("m_lo", result_lo, m_lo);
      check("m_dz", div_zero, m_dz);
    end
  end

  // Called at posedge+1; returns cycles from start to done
  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    op = o; opa = a; opb = b; start = 1'b1;
    #1 check("stall_on_start", stall_req, 1);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic expect_res(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dzv);
    check({name, "_hi"}, result_hi, hi);
    check({name, "_lo"}, result_lo, lo);
    check({name, "_dz"}, div_zero, dzv);
  endtask

  int lat, cnt_done;

  initial begin
    #2;
    check("rst_done", done, 0);
    check("rst_hi", result_hi, 0);
    check("rst_lo", result_lo, 0);
    check("rst_dz", div_zero, 0);
    check("rst_stall", stall_req, 0);
    #10 resetn = 1'b1;
    @(posedge clk); #1;

    run(2'b00, 32'hFFFF_FFFE, 32'd3, lat);
    check("mult_lat", lat, 33);
    expect_res("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    @(posedge clk); #1;
    check("done_single", done, 0);

    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    expect_res("multu", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    run(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_lat", lat, 33);
    expect_res("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    run(2'b11, 32'hFFFF_FFF9, 32'd2, lat);
    expect_res("divu", 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);

    run(2'b10, 32'd100, 32'hFFFF_FFF9, lat);
    expect_res("div_mix", 32'd2, 32'hFFFF_FFF2, 1'b0);

    run(2'b10, 32'hFFFF_FFF7, 32'd0, lat);
    check("sdz_lat", lat, EO_LAT);
    expect_res("sdivz", 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);

    run(2'b11, 32'd5, 32'd0, lat);
    check("divz_lat", lat, EO_LAT);
    expect_res("divz", 32'd5, 32'hFFFF_FFFF, 1'b1);

    // annul at cycle 10 of a divide
    op = 2'b10; opa = 32'd1000; opb = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    annul = 1'b1;
    #1 check("annul_stall", stall_req, 0);
    @(posedge clk); #1; annul = 1'b0;
    #1 check("annul_idle_stall", stall_req, 0);
    cnt_done = 0;
    repeat (40) begin @(posedge clk); #1; if (done) cnt_done++; end
    check("annul_no_done", cnt_done, 0);
    expect_res("annul_keep", 32'd5, 32'hFFFF_FFFF, 1'b1);

    // start with annul in IDLE is dropped
    op = 2'b01; opa = 32'd9; opb = 32'd9; start = 1'b1; annul = 1'b1;
    #1 check("sa_stall", stall_req, 0);
    @(posedge clk); #1; start = 1'b0; annul = 1'b0;
    #1 check("sa_idle", stall_req, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("sa_no_done", done, 0);

    // start during CALC is ignored
    op = 2'b01; opa = 32'd7; opb = 32'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; lat = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    op = 2'b11; opa = 32'd1; opb = 32'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; lat++;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    check("ign_lat", lat, 33);
    expect_res("ign", 32'd0, 32'd42, 1'b0);

    // min / -1, then back-to-back start in the DONE cycle
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    expect_res("minneg", 32'h0, 32'h8000_0000, 1'b0);
    run(2'b00, 32'h0000_1234, 32'hFFFF_FFFF, lat);
    check("b2b_lat", lat, 33);
    expect_res("b2b", 32'hFFFF_FFFF, 32'hFFFF_EDCC, 1'b0);

    // operations eligible for early out
    run(2'b10, 32'd3, 32'd10, lat);
    check("small_lat", lat, EO_LAT);
    expect_res("small", 32'd3, 32'd0, 1'b0);
    run(2'b10, 32'hFFFF_FFFD, 32'd10, lat);
    expect_res("small_neg", 32'hFFFF_FFFD, 32'd0, 1'b0);
    run(2'b00, 32'd0, 32'hFFFF_FFFB, lat);
    check("mz_lat", lat, EO_LAT);
    expect_res("mz", 32'd0, 32'd0, 1'b0);
    run(2'b11, 32'd1000, 32'd7, lat);
    expect_res("divu_b", 32'd6, 32'd142, 1'b0);

    // reset in the middle of CALC
    op = 2'b10; opa = 32'd1000; opb = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 resetn = 1'b0;
    #1;
    check("mrst_done", done, 0);
    check("mrst_hi", result_hi, 0);
    check("mrst_lo", result_lo, 0);
    check("mrst_dz", div_zero, 0);
    check("mrst_stall", stall_req, 0);
    @(posedge clk); #3 resetn = 1'b1;
    cnt_done = 0;
    repeat (40) begin @(posedge clk); #1; if (done) cnt_done++; end
    check("mrst_no_done", cnt_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
